// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO in front of a combinational 4-bit ALU, with a
// registered response stage, derived Z/N/V flags and the architectural flag
// register. Optional build macro: ALU_OP_CNT_EN adds saturating per-opcode
// completion counters on op_cnt (tied to zero otherwise).
module alu_issue_stage #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_in1,
   input  logic [3:0]               cmd_in2,
   input  logic [1:0]               cmd_op,
   output logic [3:0]               alu_in1,
   output logic [3:0]               alu_in2,
   output logic [1:0]               alu_op,
   input  logic [3:0]               alu_out,
   input  logic                     alu_err,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [3:0]               rsp_result,
   output logic [1:0]               rsp_op,
   output logic                     rsp_z,
   output logic                     rsp_n,
   output logic                     rsp_v,
   output logic [2:0]               flags,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [63:0]              op_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Overflow is only meaningful for ADD (0) and SUB (1); opcode bit 1 marks logical ops.
   function automatic logic ovf_mask(input logic [1:0] op, input logic err);
      return ~op[1] & err;
   endfunction

   function automatic logic is_zero(input logic [3:0] v);
      return (v == 4'd0);
   endfunction

   logic [9:0]    mem_p0 [DEPTH];
   logic [9:0]    head_p0;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          adv;

   // Ready only looks at occupancy, so a full FIFO stalls even on a same-cycle pop.
   assign cmd_ready = (fifo_count < DEPTH_C);
   assign push      = cmd_valid & cmd_ready;
   assign adv       = (fifo_count != '0) & (~rsp_valid | rsp_ready);

   // Head entry feeds the ALU; an empty FIFO presents zeros instead of stale storage.
   assign head_p0 = (fifo_count != '0) ? mem_p0[rd_ptr] : 10'd0;
   assign alu_in1 = head_p0[9:6];
   assign alu_in2 = head_p0[5:2];
   assign alu_op  = head_p0[1:0];

   // Command storage: data only, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push)
         mem_p0[wr_ptr] <= {cmd_in1, cmd_in2, cmd_op};
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (adv)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, adv})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Response register: captures the ALU result on advance, clears once consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_result <= 4'd0;
         rsp_op     <= 2'd0;
         rsp_z      <= 1'b0;
         rsp_n      <= 1'b0;
         rsp_v      <= 1'b0;
      end else if (adv) begin
         rsp_valid  <= 1'b1;
         rsp_result <= alu_out;
         rsp_op     <= alu_op;
         rsp_z      <= is_zero(alu_out);
         rsp_n      <= alu_out[3];
         rsp_v      <= ovf_mask(alu_op, alu_err);
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

   // Architectural flags {Z,V,N}: logical ops only update Z, V and N hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= 3'b000;
      end else if (adv) begin
         flags[2] <= is_zero(alu_out);
         if (!alu_op[1]) begin
            flags[1] <= alu_err;
            flags[0] <= alu_out[3];
         end
      end
   end

`ifdef ALU_OP_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] cnt_q [4];

   // Per-opcode completion counters, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++)
            cnt_q[i] <= 16'd0;
      end else if (adv) begin
         cnt_q[alu_op] <= sat_inc16(cnt_q[alu_op]);
      end
   end

   assign op_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
   assign op_cnt = 64'd0;
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Command buffer and result-capture stage wrapped around the combinational 4-bit ALU (ops: ADD, SUB, NAND, XOR).
- Accepts operand/opcode commands over a valid/ready handshake and queues them in a FIFO.
- Drives the queue head onto the ALU, then registers ALU_Out/Error into a response register with derived Z/N/V flags.
- Maintains the architectural flag register consumed by branch logic.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  stage can accept a command
cmd_in1  input  4  operand A
cmd_in2  input  4  operand B
cmd_op  input  2  0=ADD 1=SUB 2=NAND 3=XOR
alu_in1  output  4  to ALU_In1
alu_in2  output  4  to ALU_In2
alu_op  output  2  to ALU Opcode
alu_out  input  4  from ALU_Out
alu_err  input  1  from ALU Error (overflow)
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  downstream consumes response
rsp_result  output  4  registered ALU result
rsp_op  output  2  opcode of the response
rsp_z  output  1  result == 0
rsp_n  output  1  result[3]
rsp_v  output  1  overflow; ADD/SUB only
flags  output  3  architectural {Z,V,N}
fifo_count  output  log2(DEPTH)+1  FIFO occupancy
op_cnt  output  64  {xor,nand,sub,add} 16-bit completion counters (feature only)

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count = 0; rsp_valid, rsp_result, rsp_op, rsp_z, rsp_n, rsp_v = 0; flags = 3'b000; op_cnt = 0. Reset mid-operation discards all queued and registered work. No output is X after reset.
- cmd_ready = (fifo_count < DEPTH). No bypass: a full FIFO deasserts ready even if a pop occurs in the same cycle.
- Push: cmd_valid & cmd_ready at an edge writes {in1,in2,op} at wr_ptr; wr_ptr increments modulo DEPTH.
- ALU drive: alu_in1/alu_in2/alu_op come combinationally from the FIFO head entry. When the FIFO is empty they are 0.
- Advance condition: fifo_count != 0 & (!rsp_valid | rsp_ready). On advance:
  - Pop the head; rd_ptr increments modulo DEPTH.
  - Load rsp_result = alu_out and rsp_op = head op.
  - Load rsp_z = (alu_out == 0) and rsp_n = alu_out[3].
  - Load rsp_v = alu_err if op is ADD or SUB, else 0. Error is masked for logical ops regardless of its value.
  - Set rsp_valid = 1.
- rsp_valid drops: when rsp_valid & rsp_ready and no advance in the same cycle. Advancing while rsp_ready is high gives back-to-back responses, one per cycle.
- Latency: a command accepted at edge k with an empty FIFO and free response register gives rsp_valid = 1 after edge k+1. Sustained throughput is 1 per cycle.
- Occupancy: simultaneous push and pop leaves fifo_count unchanged; push only adds 1; pop only subtracts 1.
- Flag register, updated on each advance:
  - ADD/SUB: Z, V and N are all written.
  - NAND/XOR: only Z is written; V and N hold.
- Maximum outstanding with rsp_ready = 0 is DEPTH + 1 (FIFO plus response register).
- Pointers wrap silently. Count never exceeds DEPTH and never underflows.

Optional Feature:
- ALU_OP_CNT_EN defined:
  - Four 16-bit counters, one per opcode, increment on each advance for the popped op.
  - Counters saturate at 0xFFFF and reset to 0.
  - Packed as op_cnt[15:0] = ADD, [31:16] = SUB, [47:32] = NAND, [63:48] = XOR.
- Not defined: no counter logic; op_cnt is tied to 0. The port stays present so the integration is identical in both builds.

Test Plan:
- Reset, then a single ADD 0x7+0x1 with rsp_ready=1: alu_in1=0x7 one cycle after accept; next cycle rsp_valid=1, rsp_result=0x8, rsp_n=1, rsp_v=1, rsp_z=0; flags=3'b011.
- SUB 0x3-0x3, then XOR 0x5^0x5, then NAND 0xF,0xF, back-to-back with rsp_ready=1: three consecutive responses 0x0/0x0/0x0, all rsp_z=1, rsp_v=0. flags after SUB = 3'b100, and Z=1 with V,N held after the logical ops.
- Hold rsp_ready=0 and present 7 commands: exactly DEPTH+1=5 accepted, fifo_count=4, cmd_ready=0. Release rsp_ready: responses arrive in issue order, one per cycle, then cmd_ready returns high.
- XOR 0x8^0x1 with alu_err forced to 1 by the bench: rsp_v=0, rsp_n=1, result 0x9; flags V/N unchanged from the prior value.
- Assert rst_n=0 asynchronously with 3 queued commands and rsp_valid=1: rsp_valid, fifo_count and flags are 0 immediately. After release, the first new command returns the correct result with no stale responses.
- With ALU_OP_CNT_EN defined: 70000 random commands with rsp_ready=1 give per-opcode counts matching the bench tallies, saturated at 0xFFFF where a tally exceeds 65535. Without the macro, op_cnt stays 0.
